lc2k_multicycle_ctrl: RTL and testbench

Multicycle control FSM for the LC2K CPU datapath. It sequences fetch, decode, execute, memory and write-back for all eight LC2K opcodes. It drives the register-file write-port select (CONTROL_WRITE_REG, consumed by the write-register mux), write enables, ALU and PC source selects, and a req/ready handshake to unified memory.

---
 rtl/lc2k_multicycle_ctrl.sv | 276 +++++++++++++++++++++++++++
 tb/tb_lc2k_multicycle_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lc2k_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lc2k_multicycle_ctrl
// Description : Multicycle control FSM for the LC2K CPU datapath. Sequences
//               FETCH / DECODE / EXEC / MEM / WB for all eight opcodes and
//               handshakes with a unified memory via mem_req / mem_ready.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   MEM_TIMEOUT        nonzero: cycles mem_req may wait for mem_ready before
//                      the FSM enters ERROR; 0 disables the timeout
// Optional build macro:
//   LC2K_CTRL_PERF_CNT_EN  adds retired_cnt[31:0] (retired-instruction count)
// Ports:
//   clk                system clock, rising edge
//   rst_n              asynchronous active-low reset
//   opcode[2:0]        IR[24:22], valid from DECODE onward
//   alu_eq             ALU equality flag, valid in EXEC
//   mem_ready          memory completes the current access this cycle
//   mem_req            memory access request
//   mem_we             1 = store, 0 = load/fetch
//   mem_addr_sel       0 = PC, 1 = ALU result
//   ir_write           load IR from mem_rdata
//   pc_write           load PC from pc_src result
//   pc_src[1:0]        0 = PC+1, 1 = PC+1+offset, 2 = regA
//   alu_op[1:0]        0 = add, 1 = nor, 2 = sub/compare
//   alu_src_b          0 = regB, 1 = sign-extended offset
//   reg_write_en       register-file write strobe
//   CONTROL_WRITE_REG  1 = destReg (add/nor), 0 = regB (lw/jalr)
//   wb_sel[1:0]        0 = ALU, 1 = mem_rdata, 2 = PC+1
//   halted             halt retired; sticky until reset
//   error              memory timeout; sticky until reset
// ============================================================================
module lc2k_multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  opcode,
    input  logic        alu_eq,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_op,
    output logic        alu_src_b,
    output logic        reg_write_en,
    output logic        CONTROL_WRITE_REG,
    output logic [1:0]  wb_sel,
    output logic        halted,
    output logic        error
`ifdef LC2K_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] retired_cnt
`endif
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALTED = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_NOR  = 3'b001;
    localparam logic [2:0] c_OP_LW   = 3'b010;
    localparam logic [2:0] c_OP_SW   = 3'b011;
    localparam logic [2:0] c_OP_BEQ  = 3'b100;
    localparam logic [2:0] c_OP_JALR = 3'b101;
    localparam logic [2:0] c_OP_HALT = 3'b110;
    localparam logic [2:0] c_OP_NOOP = 3'b111;

    state_t      r_state;
    logic [2:0]  r_op;
    logic [31:0] r_to_cnt;

    // Registered strobes. r_fetch / r_beq mark states whose write strobes
    // must be qualified by the same-cycle mem_ready / alu_eq input.
    logic        r_req, r_we, r_asel, r_fetch, r_beq, r_pcw;
    logic [1:0]  r_pcs, r_aop, r_wbs;
    logic        r_srcb, r_rwe, r_cwr, r_hlt, r_err;

    state_t      w_state_next;
    logic [2:0]  w_op_next;
    logic        w_wait;
    logic        w_to_hit;
    logic        w_req, w_we, w_asel, w_fetch, w_beq, w_pcw;
    logic [1:0]  w_pcs, w_aop, w_wbs;
    logic        w_srcb, w_rwe, w_cwr, w_hlt, w_err;

    // A memory-waiting cycle: request outstanding and not completed.
    assign w_wait   = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
    // Limit hit only on a waiting cycle, so mem_ready on that cycle wins.
    assign w_to_hit = (MEM_TIMEOUT != 0) && w_wait &&
                      ((r_to_cnt + 32'd1) == MEM_TIMEOUT);

    assign w_op_next = (r_state == S_DECODE) ? opcode : r_op;

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RESET:  w_state_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready)     w_state_next = S_DECODE;
                else if (w_to_hit) w_state_next = S_ERROR;
            end
            S_DECODE: begin
                if (opcode == c_OP_HALT)      w_state_next = S_HALTED;
                else if (opcode == c_OP_NOOP) w_state_next = S_FETCH;
                else                          w_state_next = S_EXEC;
            end
            S_EXEC: begin
                case (r_op)
                    c_OP_LW, c_OP_SW: w_state_next = S_MEM;
                    c_OP_BEQ:         w_state_next = S_FETCH;
                    c_OP_ADD, c_OP_NOR, c_OP_JALR: w_state_next = S_WB;
                    default:          w_state_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ready)     w_state_next = (r_op == c_OP_SW) ? S_FETCH : S_WB;
                else if (w_to_hit) w_state_next = S_ERROR;
            end
            S_WB:     w_state_next = S_FETCH;
            S_HALTED: w_state_next = S_HALTED;
            S_ERROR:  w_state_next = S_ERROR;
            default:  w_state_next = S_RESET;
        endcase
    end

    // Output decode of the upcoming state, registered below so the outputs
    // have no combinational path from opcode.
    always_comb begin
        w_req   = 1'b0;
        w_we    = 1'b0;
        w_asel  = 1'b0;
        w_fetch = 1'b0;
        w_beq   = 1'b0;
        w_pcw   = 1'b0;
        w_pcs   = 2'd0;
        w_aop   = 2'd0;
        w_srcb  = 1'b0;
        w_rwe   = 1'b0;
        w_cwr   = 1'b0;
        w_wbs   = 2'd0;
        w_hlt   = 1'b0;
        w_err   = 1'b0;
        case (w_state_next)
            S_FETCH: begin
                w_req   = 1'b1;
                w_fetch = 1'b1;
            end
            S_EXEC: begin
                case (w_op_next)
                    c_OP_NOR:         w_aop  = 2'd1;
                    c_OP_LW, c_OP_SW: w_srcb = 1'b1;
                    c_OP_BEQ: begin
                        w_aop = 2'd2;
                        w_pcs = 2'd1;
                        w_beq = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                w_req  = 1'b1;
                w_asel = 1'b1;
                w_we   = (w_op_next == c_OP_SW);
            end
            S_WB: begin
                w_rwe = 1'b1;
                case (w_op_next)
                    c_OP_ADD, c_OP_NOR: w_cwr = 1'b1;
                    c_OP_LW:            w_wbs = 2'd1;
                    c_OP_JALR: begin
                        // regB takes the old PC+1 while PC takes regA in the
                        // same edge, which handles regA == regB correctly.
                        w_wbs = 2'd2;
                        w_pcw = 1'b1;
                        w_pcs = 2'd2;
                    end
                    default: ;
                endcase
            end
            S_HALTED: w_hlt = 1'b1;
            S_ERROR:  w_err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_RESET;
            r_op     <= 3'd0;
            r_to_cnt <= 32'd0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_asel   <= 1'b0;
            r_fetch  <= 1'b0;
            r_beq    <= 1'b0;
            r_pcw    <= 1'b0;
            r_pcs    <= 2'd0;
            r_aop    <= 2'd0;
            r_srcb   <= 1'b0;
            r_rwe    <= 1'b0;
            r_cwr    <= 1'b0;
            r_wbs    <= 2'd0;
            r_hlt    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_op     <= w_op_next;
            r_to_cnt <= (w_wait && (MEM_TIMEOUT != 0)) ? (r_to_cnt + 32'd1) : 32'd0;
            r_req    <= w_req;
            r_we     <= w_we;
            r_asel   <= w_asel;
            r_fetch  <= w_fetch;
            r_beq    <= w_beq;
            r_pcw    <= w_pcw;
            r_pcs    <= w_pcs;
            r_aop    <= w_aop;
            r_srcb   <= w_srcb;
            r_rwe    <= w_rwe;
            r_cwr    <= w_cwr;
            r_wbs    <= w_wbs;
            r_hlt    <= w_hlt;
            r_err    <= w_err;
        end
    end

    assign mem_req           = r_req;
    assign mem_we            = r_we;
    assign mem_addr_sel      = r_asel;
    assign ir_write          = r_fetch & mem_ready;
    assign pc_write          = r_pcw | (r_fetch & mem_ready) | (r_beq & alu_eq);
    assign pc_src            = r_pcs;
    assign alu_op            = r_aop;
    assign alu_src_b         = r_srcb;
    assign reg_write_en      = r_rwe;
    assign CONTROL_WRITE_REG = r_cwr;
    assign wb_sel            = r_wbs;
    assign halted            = r_hlt;
    assign error             = r_err;

`ifdef LC2K_CTRL_PERF_CNT_EN
    logic [31:0] r_retired_cnt;
    logic        w_retire;

    assign w_retire = (r_state == S_WB) ||
                      ((r_state == S_EXEC) && (r_op == c_OP_BEQ)) ||
                      ((r_state == S_MEM) && mem_ready && (r_op == c_OP_SW)) ||
                      ((r_state == S_DECODE) &&
                       ((opcode == c_OP_HALT) || (opcode == c_OP_NOOP)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired_cnt <= 32'd0;
        end else if (w_retire) begin
            r_retired_cnt <= r_retired_cnt + 32'd1;
        end
    end

    assign retired_cnt = r_retired_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lc2k_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc2k_multicycle_ctrl
// Description : Directed self-checking bench for lc2k_multicycle_ctrl. Two
//               instances share stimulus: g_dut[0] with MEM_TIMEOUT = 4 and
//               g_dut[1] with the timeout disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lc2k_multicycle_ctrl;

    // Packed observation vector bit positions:
    // 15 mem_req, 14 mem_we, 13 mem_addr_sel, 12 ir_write, 11 pc_write,
    // 10:9 pc_src, 8:7 alu_op, 6 alu_src_b, 5 reg_write_en,
    // 4 CONTROL_WRITE_REG, 3:2 wb_sel, 1 halted, 0 error
    localparam logic [15:0] c_REQ  = 16'h8000;
    localparam logic [15:0] c_WE   = 16'h4000;
    localparam logic [15:0] c_ASEL = 16'h2000;
    localparam logic [15:0] c_IRW  = 16'h1000;
    localparam logic [15:0] c_PCW  = 16'h0800;
    localparam logic [15:0] c_PCS1 = 16'h0200;
    localparam logic [15:0] c_PCS2 = 16'h0400;
    localparam logic [15:0] c_AOP1 = 16'h0080;
    localparam logic [15:0] c_AOP2 = 16'h0100;
    localparam logic [15:0] c_SRCB = 16'h0040;
    localparam logic [15:0] c_RWE  = 16'h0020;
    localparam logic [15:0] c_CWR  = 16'h0010;
    localparam logic [15:0] c_WB1  = 16'h0004;
    localparam logic [15:0] c_WB2  = 16'h0008;
    localparam logic [15:0] c_HLT  = 16'h0002;
    localparam logic [15:0] c_ERR  = 16'h0001;

    localparam logic [15:0] E_IDLE      = 16'h0000;
    localparam logic [15:0] E_FETCH_RDY = c_REQ | c_IRW | c_PCW;
    localparam logic [15:0] E_FETCH_WT  = c_REQ;
    localparam logic [15:0] E_EX_NOR    = c_AOP1;
    localparam logic [15:0] E_EX_LS     = c_SRCB;
    localparam logic [15:0] E_EX_BEQ_T  = c_AOP2 | c_PCS1 | c_PCW;
    localparam logic [15:0] E_EX_BEQ_F  = c_AOP2 | c_PCS1;
    localparam logic [15:0] E_MEM_LW    = c_REQ | c_ASEL;
    localparam logic [15:0] E_MEM_SW    = c_REQ | c_ASEL | c_WE;
    localparam logic [15:0] E_WB_ALU    = c_RWE | c_CWR;
    localparam logic [15:0] E_WB_LW     = c_RWE | c_WB1;
    localparam logic [15:0] E_WB_JALR   = c_RWE | c_WB2 | c_PCW | c_PCS2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] opcode;
    logic       alu_eq;
    logic       mem_ready;

    logic [15:0] vec [2];
`ifdef LC2K_CTRL_PERF_CNT_EN
    logic [31:0] rcnt [2];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        logic       mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
        logic [1:0] pc_src, alu_op, wb_sel;
        logic       alu_src_b, reg_write_en, cwr, halted, error;

        lc2k_multicycle_ctrl #(
            .MEM_TIMEOUT((k == 0) ? 4 : 0)
        ) u_dut (
            .clk               (clk),
            .rst_n             (rst_n),
            .opcode            (opcode),
            .alu_eq            (alu_eq),
            .mem_ready         (mem_ready),
            .mem_req           (mem_req),
            .mem_we            (mem_we),
            .mem_addr_sel      (mem_addr_sel),
            .ir_write          (ir_write),
            .pc_write          (pc_write),
            .pc_src            (pc_src),
            .alu_op            (alu_op),
            .alu_src_b         (alu_src_b),
            .reg_write_en      (reg_write_en),
            .CONTROL_WRITE_REG (cwr),
            .wb_sel            (wb_sel),
            .halted            (halted),
            .error             (error)
`ifdef LC2K_CTRL_PERF_CNT_EN
            ,
            .retired_cnt       (rcnt[k])
`endif
        );

        assign vec[k] = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write,
                         pc_src, alu_op, alu_src_b, reg_write_en, cwr,
                         wb_sel, halted, error};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs, check both instances, advance to just after
    // the next rising edge.
    task automatic cyc(input string tag, input logic rdy, input logic eq,
                       input logic [2:0] op, input logic [15:0] exp);
        mem_ready = rdy;
        alu_eq    = eq;
        opcode    = op;
        #1;
        check(tag, {16'd0, vec[0]}, {16'd0, exp});
        check({tag, "_t0"}, {16'd0, vec[1]}, {16'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("rst_async", {16'd0, vec[0]}, {16'd0, E_IDLE});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("reset_st", 1'b1, 1'b0, 3'b000, E_IDLE);
    endtask

    task automatic run_alu(input string tag, input logic [2:0] op, input logic [15:0] ex_exp);
        cyc({tag, "_fetch"}, 1'b1, 1'b0, op, E_FETCH_RDY);
        cyc({tag, "_dec"},   1'b1, 1'b0, op, E_IDLE);
        cyc({tag, "_exec"},  1'b1, 1'b0, op, ex_exp);
        cyc({tag, "_wb"},    1'b1, 1'b0, op, E_WB_ALU);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        opcode    = 3'b000;
        alu_eq    = 1'b0;
        mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", {16'd0, vec[0]}, {16'd0, E_IDLE});
        rst_n = 1'b1;
        cyc("reset_st", 1'b1, 1'b0, 3'b000, E_IDLE);

        // add then nor
        run_alu("add", 3'b000, E_IDLE);
        run_alu("nor", 3'b001, E_EX_NOR);

        // lw with three wait cycles in MEM
        cyc("lw_fetch", 1'b1, 1'b0, 3'b010, E_FETCH_RDY);
        cyc("lw_dec",   1'b1, 1'b0, 3'b010, E_IDLE);
        cyc("lw_exec",  1'b1, 1'b0, 3'b010, E_EX_LS);
        for (int i = 0; i < 3; i++)
            cyc($sformatf("lw_memwait%0d", i), 1'b0, 1'b0, 3'b010, E_MEM_LW);
        cyc("lw_memdone", 1'b1, 1'b0, 3'b010, E_MEM_LW);
        cyc("lw_wb",      1'b1, 1'b0, 3'b010, E_WB_LW);

        // sw, zero wait
        cyc("sw_fetch", 1'b1, 1'b0, 3'b011, E_FETCH_RDY);
        cyc("sw_dec",   1'b1, 1'b0, 3'b011, E_IDLE);
        cyc("sw_exec",  1'b1, 1'b0, 3'b011, E_EX_LS);
        cyc("sw_mem",   1'b1, 1'b0, 3'b011, E_MEM_SW);

        // beq taken, then not taken
        cyc("beqT_fetch", 1'b1, 1'b0, 3'b100, E_FETCH_RDY);
        cyc("beqT_dec",   1'b1, 1'b0, 3'b100, E_IDLE);
        cyc("beqT_exec",  1'b1, 1'b1, 3'b100, E_EX_BEQ_T);
        cyc("beqF_fetch", 1'b1, 1'b0, 3'b100, E_FETCH_RDY);
        cyc("beqF_dec",   1'b1, 1'b0, 3'b100, E_IDLE);
        cyc("beqF_exec",  1'b1, 1'b0, 3'b100, E_EX_BEQ_F);

        // jalr
        cyc("jalr_fetch", 1'b1, 1'b0, 3'b101, E_FETCH_RDY);
        cyc("jalr_dec",   1'b1, 1'b0, 3'b101, E_IDLE);
        cyc("jalr_exec",  1'b1, 1'b0, 3'b101, E_IDLE);
        cyc("jalr_wb",    1'b1, 1'b0, 3'b101, E_WB_JALR);

        // noop, then one fetch wait cycle
        cyc("noop_fetch", 1'b1, 1'b0, 3'b111, E_FETCH_RDY);
        cyc("noop_dec",   1'b1, 1'b0, 3'b111, E_IDLE);
        cyc("fetch_wait", 1'b0, 1'b0, 3'b111, E_FETCH_WT);

        // halt: sticky, no requests for 20 cycles
        cyc("halt_fetch", 1'b1, 1'b0, 3'b110, E_FETCH_RDY);
        cyc("halt_dec",   1'b1, 1'b0, 3'b110, E_IDLE);
        for (int i = 0; i < 20; i++) begin
            logic [31:0] v;
            v = i;
            cyc($sformatf("halted_%0d", i), v[0], v[1], 3'b000, c_HLT);
        end

        // reset leaves HALTED; then 3 adds + halt
        reset_pulse();
        run_alu("p_add0", 3'b000, E_IDLE);
        run_alu("p_add1", 3'b000, E_IDLE);
        run_alu("p_add2", 3'b000, E_IDLE);
        cyc("p_halt_fetch", 1'b1, 1'b0, 3'b110, E_FETCH_RDY);
        cyc("p_halt_dec",   1'b1, 1'b0, 3'b110, E_IDLE);
        #1;
        check("p_halted", {16'd0, vec[0]}, {16'd0, c_HLT});
`ifdef LC2K_CTRL_PERF_CNT_EN
        check("retired_cnt", rcnt[0], 32'd4);
`endif

        // timeout: instance 0 errors after 4 request cycles, instance 1 waits
        reset_pulse();
        for (int i = 0; i < 4; i++)
            cyc($sformatf("to_wait%0d", i), 1'b0, 1'b0, 3'b000, E_FETCH_WT);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("to_err%0d", i),  {16'd0, vec[0]}, {16'd0, c_ERR});
            check($sformatf("to_off%0d", i),  {16'd0, vec[1]}, {16'd0, E_FETCH_WT});
            @(posedge clk);
            #1;
        end

        // reset mid-access drops mem_req without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_req", {31'd0, vec[1][15]}, 32'd0);
        check("rst_mid_err", {16'd0, vec[0]}, {16'd0, E_IDLE});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
